spi_slave: RTL and testbench

Byte-oriented SPI slave that exchanges one 8-bit word per chip-select frame with an external master, in any of the four SPI modes selected at run time. It receives on `slaveMOSI` into `read_data` while shifting `In_Data` out on `slaveMISO`. Both directions are LSB first. It sits at the chip boundary and is clocked directly by the master's serial clock.

---
 rtl/spi_slave.sv | 84 ++++++++
 tb/tb_spi_slave.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// Byte SPI slave, LSB first, all four modes; clocked by the master's SCLK.
// Latency: MISO is combinational off the drive edge; read_data bit i lands on the i-th sample edge.
// Backpressure: none; slave_start=0 freezes both counters, CS_ high aborts the frame.
module spi_slave (
    input  logic       slaveSCLK,
    input  logic       reset,
    input  logic       slaveCPOL,
    input  logic       slaveCPHA,
    input  logic       slaveCS_,
    input  logic       slave_start,
    input  logic       slaveMOSI,
    input  logic [7:0] In_Data,
    output logic       slaveMISO,
    output logic [7:0] read_data
);

    // Rising edge of samp_clk is the sample edge in every mode; its falling edge is the drive edge.
    logic samp_clk;
    logic frame_clr_n;

    assign samp_clk    = slaveSCLK ^ slaveCPOL ^ slaveCPHA;
    assign frame_clr_n = reset & ~slaveCS_;

    logic [3:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] read_data_q, read_data_d;
    logic [2:0] tx_idx_q, tx_idx_d;
    logic       tx_first_q, tx_first_d;
    logic       rx_en;
    logic       tx_en;

    always_comb begin
        rx_en       = slave_start && !slaveCS_ && (rx_cnt_q < 4'd8);
        rx_cnt_d    = rx_cnt_q;
        read_data_d = read_data_q;
        if (rx_en) begin
            rx_cnt_d                    = rx_cnt_q + 4'd1;
            read_data_d[rx_cnt_q[2:0]]  = slaveMOSI;
        end
    end

    always_comb begin
        tx_en      = slave_start && !slaveCS_;
        tx_idx_d   = tx_idx_q;
        tx_first_d = tx_first_q;
        if (tx_en) begin
            tx_first_d = 1'b0;
            // In CPHA=1 the first drive edge only arms the shifter so bit 0 meets the first sample.
            if (!(slaveCPHA && tx_first_q) && (tx_idx_q != 3'd7)) begin
                tx_idx_d = tx_idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge samp_clk or negedge frame_clr_n) begin
        if (!frame_clr_n) begin
            rx_cnt_q <= 4'd0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // Received word survives CS_ high; only the chip reset clears it.
    always_ff @(posedge samp_clk or negedge reset) begin
        if (!reset) begin
            read_data_q <= 8'h00;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    always_ff @(negedge samp_clk or negedge frame_clr_n) begin
        if (!frame_clr_n) begin
            tx_idx_q   <= 3'd0;
            tx_first_q <= 1'b1;
        end else begin
            tx_idx_q   <= tx_idx_d;
            tx_first_q <= tx_first_d;
        end
    end

    assign slaveMISO = frame_clr_n ? In_Data[tx_idx_q] : 1'b0;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench acting as SPI master: runs frames in all four modes plus reset, abort,
// pause and overrun cases, comparing against hand-computed words.
module tb_spi_slave;

    logic       slaveSCLK;
    logic       reset;
    logic       slaveCPOL;
    logic       slaveCPHA;
    logic       slaveCS_;
    logic       slave_start;
    logic       slaveMOSI;
    logic [7:0] In_Data;
    logic       slaveMISO;
    logic [7:0] read_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] cap;

    spi_slave dut (
        .slaveSCLK   (slaveSCLK),
        .reset       (reset),
        .slaveCPOL   (slaveCPOL),
        .slaveCPHA   (slaveCPHA),
        .slaveCS_    (slaveCS_),
        .slave_start (slave_start),
        .slaveMOSI   (slaveMOSI),
        .In_Data     (In_Data),
        .slaveMISO   (slaveMISO),
        .read_data   (read_data)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %02h want %02h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        slaveCS_  = 1'b1;
        slaveCPOL = cpol;
        slaveCPHA = cpha;
        #10;
        slaveSCLK = cpol;
        #10;
    endtask

    // Master frame: half SCLK period is 10 time units; MISO is sampled mid-way between
    // the slave's drive edge and the master's sample edge.
    task automatic xfer(input logic [15:0] w, input int nbits, input int pause_at,
                        input bit raise_cs, output logic [15:0] c);
        c = 16'h0000;
        slaveCS_ = 1'b0;
        #10;
        for (int i = 0; i < nbits; i++) begin
            if (i == pause_at) begin
                #2;
                slave_start = 1'b0;
                slaveMOSI   = ~w[i];
                repeat (2) begin
                    #10 slaveSCLK = ~slaveCPOL;
                    #10 slaveSCLK = slaveCPOL;
                end
                #10;
                slave_start = 1'b1;
            end
            if (!slaveCPHA) begin
                slaveMOSI = w[i];
                #5;
                c[i] = slaveMISO;
                #5;
                slaveSCLK = ~slaveCPOL;
                #10;
                slaveSCLK = slaveCPOL;
            end else begin
                #10;
                slaveSCLK = ~slaveCPOL;
                slaveMOSI = w[i];
                #5;
                c[i] = slaveMISO;
                #5;
                slaveSCLK = slaveCPOL;
            end
        end
        #10;
        if (raise_cs) begin
            slaveCS_ = 1'b1;
            #10;
        end
    endtask

    initial begin
        slaveSCLK   = 1'b0;
        reset       = 1'b0;
        slaveCPOL   = 1'b0;
        slaveCPHA   = 1'b0;
        slaveCS_    = 1'b1;
        slave_start = 1'b1;
        slaveMOSI   = 1'b0;
        In_Data     = 8'h00;
        #15;
        chk("rst_rd", read_data, 8'h00);
        chk("rst_miso", {7'b0, slaveMISO}, 8'h00);
        reset = 1'b1;
        In_Data = 8'hFF;
        #10;
        chk("idle_miso", {7'b0, slaveMISO}, 8'h00);

        set_mode(1'b0, 1'b0);
        In_Data = 8'h0F;
        xfer(16'h00AA, 8, -1, 1'b1, cap);
        chk("m0_rd", read_data, 8'hAA);
        chk("m0_cap", cap[7:0], 8'h0F);

        set_mode(1'b0, 1'b1);
        In_Data = 8'hD8;
        xfer(16'h0076, 8, -1, 1'b1, cap);
        chk("m1_rd", read_data, 8'h76);
        chk("m1_cap", cap[7:0], 8'hD8);

        set_mode(1'b1, 1'b0);
        In_Data = 8'h59;
        xfer(16'h0000, 8, -1, 1'b1, cap);
        chk("m2_rd", read_data, 8'h00);
        chk("m2_cap", cap[7:0], 8'h59);

        set_mode(1'b1, 1'b1);
        In_Data = 8'h1B;
        xfer(16'h00FF, 8, -1, 1'b1, cap);
        chk("m3_rd", read_data, 8'hFF);
        chk("m3_cap", cap[7:0], 8'h1B);

        // Reset after 3 bits: 0xFF with bits 0..2 replaced by 1,1,0 gives 0xFB.
        set_mode(1'b0, 1'b0);
        In_Data = 8'hA5;
        xfer(16'h0033, 3, -1, 1'b0, cap);
        chk("part_rd", read_data, 8'hFB);
        reset = 1'b0;
        #5;
        chk("midrst_rd", read_data, 8'h00);
        chk("midrst_miso", {7'b0, slaveMISO}, 8'h00);
        slaveCS_ = 1'b1;
        #5;
        reset = 1'b1;
        #10;
        xfer(16'h003C, 8, -1, 1'b1, cap);
        chk("postrst_rd", read_data, 8'h3C);
        chk("postrst_cap", cap[7:0], 8'hA5);

        // CS abort after 4 bits: low nibble of 0x3C overwritten with 0xF.
        In_Data = 8'h96;
        xfer(16'h000F, 4, -1, 1'b1, cap);
        chk("abort_rd", read_data, 8'h3F);
        chk("abort_miso", {7'b0, slaveMISO}, 8'h00);
        xfer(16'h00C3, 8, -1, 1'b1, cap);
        chk("restart_rd", read_data, 8'hC3);
        chk("restart_cap", cap[7:0], 8'h96);

        set_mode(1'b0, 1'b1);
        In_Data = 8'h4E;
        xfer(16'h0081, 8, 3, 1'b1, cap);
        chk("pause_rd", read_data, 8'h81);
        chk("pause_cap", cap[7:0], 8'h4E);

        set_mode(1'b0, 1'b0);
        In_Data = 8'h9C;
        xfer(16'h016A, 9, -1, 1'b1, cap);
        chk("ovr_rd", read_data, 8'h6A);
        chk("ovr_cap", cap[7:0], 8'h9C);
        chk("ovr_miso9", {7'b0, cap[8]}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
